nabp_filtered_ram_swap: RTL and testbench

// - Ping-pong filtered-projection store between the filter and the processing data path.
// - Filter side writes one filtered projection line, tagged with its angle, into the fill bank.
// - Processing side reads the other bank through two independent s-indexed ports (pv0/pv1).
// - Banks swap by handshake, so filtering of angle n+1 overlaps backprojection of angle n.

---
 rtl/nabp_filtered_ram_swap.sv | 194 +++++++++++++++++++
 tb/tb_nabp_filtered_ram_swap.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/nabp_filtered_ram_swap.sv
// -----------------------------------------------------------------------------
// nabp_filtered_ram_swap
//
// Ping-pong store for filtered projection lines. The filter fills one bank
// (the fill bank) with a complete line and closes it with fr_done, which also
// tags the bank with its angle. The processing path owns the other bank (the
// read bank) and reads it through two independent registered ports. It hands
// the bank back with pv_release. Filtering of angle n+1 therefore overlaps
// backprojection of angle n.
//
// Each bank walks EMPTY -> FULL -> READ -> EMPTY. The wr_bank and rd_bank
// pointers are 1 bit each. While pv_valid=1 the fill bank and the read bank
// are always different banks, so a write can never collide with a read.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset (RAM contents not reset)
//   fr_wr_en     in   filter write strobe
//   fr_wr_addr   in   filter write index s
//   fr_wr_val    in   filtered sample
//   fr_angle     in   angle of the line being filled, sampled on fr_done
//   fr_done      in   pulse: fill bank complete
//   fr_ready     out  fill bank is EMPTY and accepts writes / fr_done
//   pv0_s_val    in   read port 0 index
//   pv0_val      out  read port 0 data (1-cycle latency)
//   pv1_s_val    in   read port 1 index
//   pv1_val      out  read port 1 data (1-cycle latency)
//   pv_valid     out  read bank holds a complete line owned by processing
//   pv_angle     out  angle tag of the read bank
//   pv_release   in   pulse: processing is finished with the read bank
//
// Build option
//   NABP_FILTERED_RAM_OOR_ZERO_EN : when defined, reads at s >= LINE_LENGTH
//   return 0 and writes at s >= LINE_LENGTH are dropped. When undefined, the
//   full 2**S_WIDTH address space is used as-is.
// -----------------------------------------------------------------------------
module nabp_filtered_ram_swap #(
   parameter int DATA_WIDTH  = 12,
   parameter int S_WIDTH     = 9,
   parameter int ANGLE_WIDTH = 9,
   parameter int LINE_LENGTH = 363
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   fr_wr_en,
   input  logic [S_WIDTH-1:0]     fr_wr_addr,
   input  logic [DATA_WIDTH-1:0]  fr_wr_val,
   input  logic [ANGLE_WIDTH-1:0] fr_angle,
   input  logic                   fr_done,
   output logic                   fr_ready,
   input  logic [S_WIDTH-1:0]     pv0_s_val,
   output logic [DATA_WIDTH-1:0]  pv0_val,
   input  logic [S_WIDTH-1:0]     pv1_s_val,
   output logic [DATA_WIDTH-1:0]  pv1_val,
   output logic                   pv_valid,
   output logic [ANGLE_WIDTH-1:0] pv_angle,
   input  logic                   pv_release
);

   localparam int DEPTH = 2 ** S_WIDTH;

`ifdef NABP_FILTERED_RAM_OOR_ZERO_EN
   localparam bit OOR_CHECK = 1'b1;
`else
   localparam bit OOR_CHECK = 1'b0;
`endif

   // Line length widened by one bit so a length equal to the bank depth
   // still compares correctly.
   localparam logic [S_WIDTH:0] LINE_LEN_W = (S_WIDTH + 1)'(LINE_LENGTH);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      READ  = 2'd2
   } bank_state_t;

   bank_state_t            bank_state_reg  [2];
   bank_state_t            bank_state_next [2];
   logic [ANGLE_WIDTH-1:0] tag_reg         [2];
   logic [ANGLE_WIDTH-1:0] tag_next        [2];
   logic                   wr_bank_reg, wr_bank_next;
   logic                   rd_bank_reg, rd_bank_next;
   logic                   pv_valid_reg, pv_valid_next;
   logic [ANGLE_WIDTH-1:0] pv_angle_reg, pv_angle_next;
   logic [DATA_WIDTH-1:0]  pv0_val_reg, pv1_val_reg;

   logic [DATA_WIDTH-1:0]  rd0_word [2];
   logic [DATA_WIDTH-1:0]  rd1_word [2];

   // With the range check disabled these reduce to constant 1.
   logic wr_in_range, rd0_in_range, rd1_in_range;
   assign wr_in_range  = !OOR_CHECK || ({1'b0, fr_wr_addr} < LINE_LEN_W);
   assign rd0_in_range = !OOR_CHECK || ({1'b0, pv0_s_val}  < LINE_LEN_W);
   assign rd1_in_range = !OOR_CHECK || ({1'b0, pv1_s_val}  < LINE_LEN_W);

   assign fr_ready = (bank_state_reg[wr_bank_reg] == EMPTY);

   logic wr_fire;
   assign wr_fire = fr_wr_en && fr_ready && wr_in_range;

   // ---------------------------------------------------------------------
   // Bank storage: one RAM per bank. A bank is written only while it is the
   // fill bank and EMPTY. Both read ports see both banks, and the rd_bank
   // mux sits in front of the output registers.
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

         always_ff @(posedge clk) begin
            if (wr_fire && (wr_bank_reg == 1'(gi))) begin
               mem[fr_wr_addr] <= fr_wr_val;
            end
         end

         assign rd0_word[gi] = mem[pv0_s_val];
         assign rd1_word[gi] = mem[pv1_s_val];
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Ownership next-state. Closing the fill bank and releasing the read
   // bank always act on different banks, so both may happen at one edge.
   // Acquire looks only at registered state, which gives one full cycle
   // between fr_done/pv_release and pv_valid rising.
   // ---------------------------------------------------------------------
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         bank_state_next[b] = bank_state_reg[b];
         tag_next[b]        = tag_reg[b];
      end
      wr_bank_next  = wr_bank_reg;
      rd_bank_next  = rd_bank_reg;
      pv_valid_next = pv_valid_reg;
      pv_angle_next = pv_angle_reg;

      if (fr_done && fr_ready) begin
         bank_state_next[wr_bank_reg] = FULL;
         tag_next[wr_bank_reg]        = fr_angle;
         wr_bank_next                 = ~wr_bank_reg;
      end

      if (pv_release && pv_valid_reg) begin
         bank_state_next[rd_bank_reg] = EMPTY;
         rd_bank_next                 = ~rd_bank_reg;
         pv_valid_next                = 1'b0;
      end else if (!pv_valid_reg && (bank_state_reg[rd_bank_reg] == FULL)) begin
         bank_state_next[rd_bank_reg] = READ;
         pv_valid_next                = 1'b1;
         pv_angle_next                = tag_reg[rd_bank_reg];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int b = 0; b < 2; b++) begin
            bank_state_reg[b] <= EMPTY;
            tag_reg[b]        <= '0;
         end
         wr_bank_reg  <= 1'b0;
         rd_bank_reg  <= 1'b0;
         pv_valid_reg <= 1'b0;
         pv_angle_reg <= '0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            bank_state_reg[b] <= bank_state_next[b];
            tag_reg[b]        <= tag_next[b];
         end
         wr_bank_reg  <= wr_bank_next;
         rd_bank_reg  <= rd_bank_next;
         pv_valid_reg <= pv_valid_next;
         pv_angle_reg <= pv_angle_next;
      end
   end

   // Registered reads run every cycle, valid or not. Stale data is harmless.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pv0_val_reg <= '0;
         pv1_val_reg <= '0;
      end else begin
         pv0_val_reg <= rd0_in_range ? rd0_word[rd_bank_reg] : '0;
         pv1_val_reg <= rd1_in_range ? rd1_word[rd_bank_reg] : '0;
      end
   end

   assign pv0_val  = pv0_val_reg;
   assign pv1_val  = pv1_val_reg;
   assign pv_valid = pv_valid_reg;
   assign pv_angle = pv_angle_reg;

endmodule

// File: tb/tb_nabp_filtered_ram_swap.sv
// -----------------------------------------------------------------------------
// tb_nabp_filtered_ram_swap
//
// Directed bench for the ping-pong filtered projection store. Inputs change
// just after the falling edge. Outputs are checked at the following falling
// edge, half a cycle after the rising edge that updates them.
// -----------------------------------------------------------------------------
module tb_nabp_filtered_ram_swap;

   localparam int DW = 12;
   localparam int SW = 9;
   localparam int AW = 9;
   localparam int LL = 363;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          fr_wr_en;
   logic [SW-1:0] fr_wr_addr;
   logic [DW-1:0] fr_wr_val;
   logic [AW-1:0] fr_angle;
   logic          fr_done;
   logic          fr_ready;
   logic [SW-1:0] pv0_s_val;
   logic [DW-1:0] pv0_val;
   logic [SW-1:0] pv1_s_val;
   logic [DW-1:0] pv1_val;
   logic          pv_valid;
   logic [AW-1:0] pv_angle;
   logic          pv_release;

   int errors = 0;
   int checks = 0;

   nabp_filtered_ram_swap #(
      .DATA_WIDTH (DW),
      .S_WIDTH    (SW),
      .ANGLE_WIDTH(AW),
      .LINE_LENGTH(LL)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .fr_wr_en  (fr_wr_en),
      .fr_wr_addr(fr_wr_addr),
      .fr_wr_val (fr_wr_val),
      .fr_angle  (fr_angle),
      .fr_done   (fr_done),
      .fr_ready  (fr_ready),
      .pv0_s_val (pv0_s_val),
      .pv0_val   (pv0_val),
      .pv1_s_val (pv1_s_val),
      .pv1_val   (pv1_val),
      .pv_valid  (pv_valid),
      .pv_angle  (pv_angle),
      .pv_release(pv_release)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
      $display("check %-18s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Writes s=k -> k+offset for k in [0, LL-1]. The last write carries no
   // fr_done unless done_on_last is set.
   task automatic fill_line(input int offset, input logic done_on_last, input logic [AW-1:0] angle);
      for (int k = 0; k < LL; k++) begin
         fr_wr_en   = 1'b1;
         fr_wr_addr = SW'(k);
         fr_wr_val  = DW'(k + offset);
         if (done_on_last && (k == LL - 1)) begin
            fr_done  = 1'b1;
            fr_angle = angle;
         end
         tick();
      end
      fr_wr_en = 1'b0;
      fr_done  = 1'b0;
   endtask

   initial begin
      reset_n    = 1'b0;
      fr_wr_en   = 1'b0;
      fr_wr_addr = '0;
      fr_wr_val  = '0;
      fr_angle   = '0;
      fr_done    = 1'b0;
      pv0_s_val  = '0;
      pv1_s_val  = '0;
      pv_release = 1'b0;

      // ---- reset state ----
      tick();
      tick();
      check("rst_pv_valid", 32'(pv_valid), 32'd0);
      check("rst_pv_angle", 32'(pv_angle), 32'd0);
      check("rst_pv0_val",  32'(pv0_val),  32'd0);
      check("rst_pv1_val",  32'(pv1_val),  32'd0);
      check("rst_fr_ready", 32'(fr_ready), 32'd1);
      reset_n = 1'b1;
      tick();

      // ---- fill B0 (angle 30); last write shares the cycle with fr_done ----
      fill_line(0, 1'b1, 9'd30);
      check("b0_done_ready",  32'(fr_ready), 32'd1);
      check("b0_done_valid0", 32'(pv_valid), 32'd0);
      tick();
      check("b0_acq_valid",   32'(pv_valid), 32'd1);
      check("b0_acq_angle",   32'(pv_angle), 32'd30);

      // ---- two independent read ports ----
      pv0_s_val = 9'd5;
      pv1_s_val = 9'd200;
      tick();
      check("b0_rd_p0_s5",   32'(pv0_val), 32'd5);
      check("b0_rd_p1_s200", 32'(pv1_val), 32'd200);
      pv0_s_val = 9'd362;
      pv1_s_val = 9'd362;
      tick();
      check("b0_rd_p0_s362", 32'(pv0_val), 32'd362);
      check("b0_rd_p1_s362", 32'(pv1_val), 32'd362);

      // ---- fill B1 (angle 31) while B0 is READ ----
      fill_line(1000, 1'b0, '0);
      check("b1_fill_valid", 32'(pv_valid), 32'd1);
      fr_done  = 1'b1;
      fr_angle = 9'd31;
      tick();
      fr_done = 1'b0;
      check("both_full_ready", 32'(fr_ready), 32'd0);
      // Blocked write would land in B0 at s=5; blocked fr_done must not retag.
      fr_wr_en   = 1'b1;
      fr_wr_addr = 9'd5;
      fr_wr_val  = 12'hABC;
      fr_done    = 1'b1;
      fr_angle   = 9'd99;
      pv0_s_val  = 9'd5;
      tick();
      fr_wr_en = 1'b0;
      fr_done  = 1'b0;
      tick();
      check("blk_wr_dropped", 32'(pv0_val),  32'd5);
      check("blk_valid",      32'(pv_valid), 32'd1);
      check("blk_angle",      32'(pv_angle), 32'd30);
      check("blk_ready",      32'(fr_ready), 32'd0);

      // ---- release B0, acquire B1 ----
      pv_release = 1'b1;
      tick();
      pv_release = 1'b0;
      check("rel_valid0", 32'(pv_valid), 32'd0);
      check("rel_ready",  32'(fr_ready), 32'd1);
      pv0_s_val = 9'd5;
      pv1_s_val = 9'd362;
      tick();
      check("b1_acq_valid", 32'(pv_valid), 32'd1);
      check("b1_acq_angle", 32'(pv_angle), 32'd31);
      check("b1_rd_p0_s5",  32'(pv0_val),  32'd1005);
      check("b1_rd_p1_s362",32'(pv1_val),  32'd1362);

      // ---- fill B0 (angle 32), plus a write beyond the line at s=400 ----
      fill_line(2000, 1'b0, '0);
      fr_wr_en   = 1'b1;
      fr_wr_addr = 9'd400;
      fr_wr_val  = 12'h5A5;
      tick();
      fr_wr_en = 1'b0;
      // fr_done on B0 and pv_release on B1 at the same edge
      fr_done    = 1'b1;
      fr_angle   = 9'd32;
      pv_release = 1'b1;
      tick();
      fr_done    = 1'b0;
      pv_release = 1'b0;
      check("sim_valid0", 32'(pv_valid), 32'd0);
      check("sim_ready",  32'(fr_ready), 32'd1);
      pv0_s_val = 9'd7;
      pv1_s_val = 9'd0;
      tick();
      check("b0b_acq_valid", 32'(pv_valid), 32'd1);
      check("b0b_acq_angle", 32'(pv_angle), 32'd32);
      check("b0b_rd_p0_s7",  32'(pv0_val),  32'd2007);
      check("b0b_rd_p1_s0",  32'(pv1_val),  32'd2000);

      // ---- access beyond LINE_LENGTH ----
      pv0_s_val = 9'd400;
      pv1_s_val = 9'd100;
      tick();
`ifdef NABP_FILTERED_RAM_OOR_ZERO_EN
      check("oor_rd_s400", 32'(pv0_val), 32'd0);
`else
      check("raw_rd_s400", 32'(pv0_val), 32'h5A5);
`endif
      check("rd_p1_s100", 32'(pv1_val), 32'd2100);

      // ---- reset in the middle of a fill ----
      fr_wr_en   = 1'b1;
      fr_wr_addr = 9'd1;
      fr_wr_val  = 12'd77;
      fr_done    = 1'b1;
      fr_angle   = 9'd40;
      tick();
      fr_wr_en = 1'b0;
      fr_done  = 1'b0;
      check("pre_rst_ready", 32'(fr_ready), 32'd0);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(pv_valid), 32'd0);
      check("mid_rst_ready", 32'(fr_ready), 32'd1);
      check("mid_rst_pv0",   32'(pv0_val),  32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      // After reset, B0 is the fill bank again and rd_bank starts at B0.
      fr_done  = 1'b1;
      fr_angle = 9'd7;
      tick();
      fr_done = 1'b0;
      tick();
      check("post_rst_valid", 32'(pv_valid), 32'd1);
      check("post_rst_angle", 32'(pv_angle), 32'd7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
